aes_decryption: RTL and testbench

Iterative AES inverse cipher (FIPS-197) that decrypts one 128-bit block with a 128-, 192- or 256-bit key, one round per clock. It starts automatically when reset is released and holds the recovered plaintext until the next reset. It sits behind the encryption core as the receive-side datapath. Round keys come from a combinational key schedule, and all S-box values come from GF(2^8) inversion plus the affine transform, so no ROM tables are needed.

---
 rtl/aes_decryption.sv | 190 +++++++++++++++++++
 tb/tb_aes_decryption.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decryption.sv
// Iterative AES inverse cipher: one round per clock, combinational key schedule, S-boxes from GF(2^8) math.
// Define AES_DEC_MULTI_KEY_EN to enable AES-128/192 via mux; otherwise the block is AES-256 only.
module aes_decryption (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] key,
  input  logic [1:0]   mux,
  input  logic [127:0] in_state,
  output logic [127:0] out_state,
  output logic [3:0]   counter
);

  logic [127:0] st;
  logic [255:0] k_r;
  logic [1:0]   m_r;
  logic         start;
  logic [255:0] key_s;
  logic [1:0]   mux_s;
  logic [3:0]   nr;
  logic [3:0]   ridx;
  logic [31:0]  w [60];
  logic [31:0]  ks_tmp;
  logic [127:0] rk;
  logic [127:0] isr_sb;
  logic [127:0] ark;
  logic [127:0] mixed;
  logic [127:0] round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 1; n < j; n++) r = xtime(r);
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // At counter 0 the schedule runs from the live inputs so rk[Nr] is ready on the first edge.
  assign start = (counter == 4'd0);
  assign key_s = start ? key : k_r;

`ifdef AES_DEC_MULTI_KEY_EN
  assign mux_s = start ? mux : m_r;
`else
  logic mux_unused;
  assign m_r        = 2'b10;
  assign mux_s      = m_r;
  assign mux_unused = ^mux;
`endif

  always_comb begin
    unique case (mux_s)
      2'b00:   nr = 4'd10;
      2'b01:   nr = 4'd12;
      default: nr = 4'd14;
    endcase
  end

  always_comb begin
    ks_tmp = '0;
    for (int i = 0; i < 8; i++) w[i] = key_s[255-32*i -: 32];
    for (int i = 8; i < 60; i++) w[i] = '0;
`ifdef AES_DEC_MULTI_KEY_EN
    for (int i = 4; i < 60; i++) begin
      ks_tmp = w[i-1];
      unique case (mux_s)
        2'b00: if (i < 44) begin
          if (i % 4 == 0) ks_tmp = sub_word(rot_word(ks_tmp)) ^ {rcon(i / 4), 24'h0};
          w[i] = w[i-4] ^ ks_tmp;
        end
        2'b01: if (i >= 6 && i < 52) begin
          if (i % 6 == 0) ks_tmp = sub_word(rot_word(ks_tmp)) ^ {rcon(i / 6), 24'h0};
          w[i] = w[i-6] ^ ks_tmp;
        end
        default: if (i >= 8) begin
          if (i % 8 == 0)      ks_tmp = sub_word(rot_word(ks_tmp)) ^ {rcon(i / 8), 24'h0};
          else if (i % 8 == 4) ks_tmp = sub_word(ks_tmp);
          w[i] = w[i-8] ^ ks_tmp;
        end
      endcase
    end
`else
    for (int i = 8; i < 60; i++) begin
      ks_tmp = w[i-1];
      if (i % 8 == 0)      ks_tmp = sub_word(rot_word(ks_tmp)) ^ {rcon(i / 8), 24'h0};
      else if (i % 8 == 4) ks_tmp = sub_word(ks_tmp);
      w[i] = w[i-8] ^ ks_tmp;
    end
`endif
  end

  assign ridx = start ? nr : (nr - counter);
  assign rk   = {w[{ridx, 2'd0}], w[{ridx, 2'd1}], w[{ridx, 2'd2}], w[{ridx, 2'd3}]};

  // Byte (row r, col c) lives at bits [127-8*(4c+r) -: 8].
  always_comb begin
    isr_sb = '0;
    mixed  = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr_sb[127-8*(4*c+r) -: 8] = inv_sbox(st[127-8*(4*((c+4-r)%4)+r) -: 8]);
      end
    end
    ark = isr_sb ^ rk;
    for (int c = 0; c < 4; c++) mixed[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    round_out = (counter == nr) ? ark : mixed;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= '0;
      k_r       <= '0;
`ifdef AES_DEC_MULTI_KEY_EN
      m_r       <= '0;
`endif
      counter   <= '0;
      out_state <= '0;
    end else if (start) begin
      k_r     <= key;
`ifdef AES_DEC_MULTI_KEY_EN
      m_r     <= mux;
`endif
      st      <= in_state ^ rk;
      counter <= 4'd1;
    end else if (counter <= nr) begin
      st      <= round_out;
      counter <= counter + 4'd1;
      if (counter == nr) out_state <= round_out;
    end
  end

endmodule

// File: tb/tb_aes_decryption.sv
// Directed and randomized bench for aes_decryption against a table-driven FIPS-197 inverse cipher model.
module tb_aes_decryption;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [255:0] key = '0;
  logic [1:0]   mux = '0;
  logic [127:0] in_state = '0;
  logic [127:0] out_state;
  logic [3:0]   counter;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];
  logic [7:0] sbox_t [256];
  logic [7:0] inv_sbox_t [256];
  logic [7:0] rcon_t [10];

  always #5 clk = ~clk;

  aes_decryption dut (
    .clk(clk),
    .reset(reset),
    .key(key),
    .mux(mux),
    .in_state(in_state),
    .out_state(out_state),
    .counter(counter)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] sw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  function automatic logic [127:0] model_decrypt(input logic [255:0] k, input logic [1:0] m,
                                                 input logic [127:0] ct);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  s [4][4];
    logic [7:0]  n [4][4];
    logic [7:0]  a [4];
    logic [127:0] res;
    int nk, nr;
    case (m)
      2'b00:   nk = 4;
      2'b01:   nk = 6;
      default: nk = 8;
    endcase
    nr = nk + 6;
    for (int i = 0; i < 60; i++) w[i] = 0;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) t = sw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk-1], 24'h0};
      else if (nk > 6 && i % nk == 4) t = sw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = ct[127-8*(4*c+r) -: 8] ^ w[4*nr+c][31-8*r -: 8];
    for (int round = nr - 1; round >= 0; round--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          n[r][(c+r)%4] = inv_sbox_t[s[r][c]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = n[r][c] ^ w[4*round+c][31-8*r -: 8];
      if (round > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[r][c];
          s[0][c] = gm(a[0], 14) ^ gm(a[1], 11) ^ gm(a[2], 13) ^ gm(a[3], 9);
          s[1][c] = gm(a[0], 9)  ^ gm(a[1], 14) ^ gm(a[2], 11) ^ gm(a[3], 13);
          s[2][c] = gm(a[0], 13) ^ gm(a[1], 9)  ^ gm(a[2], 14) ^ gm(a[3], 11);
          s[3][c] = gm(a[0], 11) ^ gm(a[1], 13) ^ gm(a[2], 9)  ^ gm(a[3], 14);
        end
      end
    end
    res = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [1:0] eff_mux(input logic [1:0] m);
    logic [1:0] e;
    e = m;
`ifndef AES_DEC_MULTI_KEY_EN
    e = 2'b10;
`endif
    return e;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // mode 0: plain run, 1: reset at counter 7 then full rerun, 2: inputs changed at counter 3
  task automatic run_block(input string tag, input logic [255:0] k, input logic [1:0] m,
                           input logic [127:0] ct, input logic [127:0] pt, input int mode);
    logic [1:0] e;
    int nr;
    logic [127:0] exp_pt;
    e = eff_mux(m);
    nr = (e == 2'b00) ? 10 : (e == 2'b01) ? 12 : 14;
    exp_q.push_back(pt);
    @(negedge clk);
    key = k; mux = m; in_state = ct; reset = 1'b1;
    #1;
    check({tag, " reset counter"}, {124'd0, counter}, 128'd0);
    check({tag, " reset out"}, out_state, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    if (mode == 1) begin
      repeat (7) @(posedge clk);
      #1;
      check({tag, " counter before abort"}, {124'd0, counter}, 128'd7);
      reset = 1'b1;
      #1;
      check({tag, " abort counter"}, {124'd0, counter}, 128'd0);
      check({tag, " abort out"}, out_state, 128'd0);
      @(negedge clk);
      reset = 1'b0;
    end
    for (int ed = 1; ed <= nr + 1; ed++) begin
      @(posedge clk);
      #1;
      check({tag, " counter"}, {124'd0, counter}, 128'(ed));
      if (mode == 2 && ed == 3) begin
        key = rand256();
        mux = 2'($urandom_range(0, 3));
        in_state = rand256()[127:0];
      end
      if (ed == nr) check({tag, " out before final"}, out_state, 128'd0);
    end
    exp_pt = exp_q.pop_front();
    check({tag, " plaintext"}, out_state, exp_pt);
    for (int h = 0; h < 3; h++) begin
      key = rand256();
      mux = 2'($urandom_range(0, 3));
      in_state = rand256()[127:0];
      @(posedge clk);
      #1;
      check({tag, " hold counter"}, {124'd0, counter}, 128'(nr + 1));
      check({tag, " hold out"}, out_state, exp_pt);
    end
  endtask

  initial begin
    logic [255:0] k256, k_r;
    logic [127:0] ct_r;
    logic [1:0]   m_r;
    logic [7:0]   inv, b, s, cst;
    cst = 8'h63;
    rcon_t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      b = inv;
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ cst[i];
      sbox_t[x] = s;
      inv_sbox_t[s] = x[7:0];
    end

    k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    reset = 1'b1;
    #12;
    check("power-on counter", {124'd0, counter}, 128'd0);
    check("power-on out", out_state, 128'd0);

    run_block("aes256", k256, 2'b10, 128'h8ea2b7ca516745bfeafc49904b496089,
              128'h00112233445566778899aabbccddeeff, 0);
    run_block("aes256 mux11", k256, 2'b11, 128'h8ea2b7ca516745bfeafc49904b496089,
              128'h00112233445566778899aabbccddeeff, 0);
`ifdef AES_DEC_MULTI_KEY_EN
    run_block("aes128", {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 2'b00,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 0);
    run_block("aes192", {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 2'b01,
              128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff, 0);
`endif
    run_block("mux00 with 256b key", k256, 2'b00, 128'h8ea2b7ca516745bfeafc49904b496089,
              model_decrypt(k256, eff_mux(2'b00), 128'h8ea2b7ca516745bfeafc49904b496089), 0);
    run_block("mid-run reset", k256, 2'b10, 128'h8ea2b7ca516745bfeafc49904b496089,
              128'h00112233445566778899aabbccddeeff, 1);
    run_block("late input change", k256, 2'b10, 128'h8ea2b7ca516745bfeafc49904b496089,
              128'h00112233445566778899aabbccddeeff, 2);

    for (int t = 0; t < 6; t++) begin
      k_r  = rand256();
      ct_r = rand256()[127:0];
      m_r  = 2'($urandom_range(0, 3));
      run_block($sformatf("random%0d", t), k_r, m_r, ct_r, model_decrypt(k_r, eff_mux(m_r), ct_r),
                (t == 5) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
